riscv_commit_checker: RTL
=========================

Name: riscv_commit_checker

Overview:
Synthesizable self-check unit for the single-cycle RISC-V core. It snoops register-file and data-memory write ports and tracks a programmable list of expected register and memory-word values. It detects end-of-program (NOP loop) or timeout, then compares every entry and reports pass/fail, error count and cycle count. It sits beside the core in FPGA and simulation tops, so a run can be self-checked without hierarchical peeking.

Parameters:
XLEN, 32, datapath width (pc, rf data, dm address/data)
NUM_CHECKS, 8, number of expected-value slots
TIMEOUT_CYCLES, 500, RUN cycles before forced abort
END_MIN_CYCLES, 5, end detection allowed only when cycle_cnt > this
END_INSTR, 32'h00000013, instruction word marking end of program

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a RUN from IDLE or DONE
cfg_we  in  1  write one check slot (accepted only in IDLE/DONE)
cfg_idx  in  $clog2(NUM_CHECKS)  slot index
cfg_en  in  1  slot enable
cfg_kind  in  1  0 = register, 1 = memory word
cfg_addr  in  XLEN  register number [4:0], or byte address (word-aligned; [1:0] ignored)
cfg_exp  in  XLEN  expected value
pc  in  XLEN  core PC
instr  in  32  current instruction
rf_we  in  1  register write enable
rf_waddr  in  5  register write address
rf_wdata  in  XLEN  register write data
dm_we  in  1  data-memory write enable
dm_addr  in  XLEN  data-memory byte address
dm_be  in  XLEN/8  byte enables, lane i = bits [8i+7:8i]
dm_wdata  in  XLEN  store data, lane-aligned
busy  out  1  high in RUN or CHECK
done  out  1  high in DONE
pass  out  1  valid when done
timeout  out  1  sticky until next start
error_cnt  out  $clog2(NUM_CHECKS+1)  mismatching enabled slots
fail_idx  out  $clog2(NUM_CHECKS)  lowest mismatching slot; 0 if none
cycle_cnt  out  32  RUN cycles elapsed, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; all slots disabled; shadows 0.
- FSM IDLE -> RUN on start. Entering RUN clears cycle_cnt, error_cnt, fail_idx, timeout and all shadows.
- RUN: cycle_cnt increments every cycle. Each enabled slot updates its shadow on a matching write:
  - register slot: rf_we && rf_waddr == cfg_addr[4:0] && rf_waddr != 0; shadow <= rf_wdata.
  - memory slot: dm_we && dm_addr[XLEN-1:2] == cfg_addr[XLEN-1:2]; lanes with dm_be set are merged, other lanes are kept.
  - One rf write and one dm write in the same cycle both apply. Multiple slots with the same address all update.
- End detection: instr == END_INSTR && cycle_cnt > END_MIN_CYCLES -> CHECK next cycle. Snoop still applies in the detecting cycle.
- Timeout: cycle_cnt == TIMEOUT_CYCLES-1 without end detection -> DONE with timeout=1 and pass=0. No compare is done. End detection takes precedence if both occur in the same cycle.
- CHECK: one slot per cycle, idx 0..NUM_CHECKS-1, so latency is exactly NUM_CHECKS cycles.
  - Disabled slots are skipped but still take their cycle.
  - On mismatch: error_cnt++. fail_idx is latched on the first mismatch only.
  - After the last slot -> DONE.
- DONE: done=1; pass = (error_cnt == 0) && !timeout. Outputs hold. start -> RUN. Slot configuration persists.
- cfg_we is ignored in RUN/CHECK. A cfg_we in the same cycle as start is applied before RUN begins.
- start in RUN/CHECK is ignored.
- Reset asserted mid-run returns to IDLE immediately and clears configuration.
- cycle_cnt saturates at 2^32-1.

Optional Feature:
RISCV_CHECK_STUCK_PC_EN: when defined, end-of-program is also detected when pc is unchanged for 2 consecutive RUN cycles after END_MIN_CYCLES (a jal x0,0 loop), tracked by one prev_pc register. When undefined, only END_INSTR ends the run; prev_pc and its logic are absent.

Decomposition:
- Package riscv_check_pkg:
  - chk_state_e {IDLE, RUN, CHECK, DONE}
  - chk_kind_e {CHK_REG, CHK_MEM}
  - NOP_INSTR constant
  - chk_slot_t struct {en, kind, addr, exp}
- Sub-module riscv_check_slot: one slot's config plus shadow register with the byte-lane merge and match logic. Instantiated NUM_CHECKS times by a generate loop. The top holds the FSM, counters and compare mux.

Test Plan:
- Program a slot list (x8=4, x9=12, x18=16, x10=16, mem[0x0]=16); drive matching writes; then END_INSTR at cycle 8 -> CHECK lasts 8 cycles; done=1, pass=1, error_cnt=0.
- Same list, but the x9 write carries 13 -> pass=0, error_cnt=1, fail_idx=1.
- Two byte stores to word 0x0 (be=0001 data 0x10, be=0010 data 0x00), expect 0x00000010 -> pass=1. Then a write to x0 with a slot on x0 expecting 0 -> shadow stays 0.
- Never present END_INSTR, with TIMEOUT_CYCLES=20 -> done at RUN cycle 20, timeout=1, pass=0, cycle_cnt=20.
- END_INSTR at cycle 3 is ignored; END_INSTR again at cycle 6 -> enters CHECK. Assert reset during CHECK -> all outputs 0, state IDLE.
- With RISCV_CHECK_STUCK_PC_EN defined: pc held at 0x24 for 2 cycles after cycle 5 -> enters CHECK. Without it -> run ends by timeout.

Source files
------------

// File: rtl/riscv_check_pkg.sv
// Shared types for the RISC-V commit checker: FSM states, slot kinds,
// the per-slot configuration record and the byte-lane merge helper.
package riscv_check_pkg;

    localparam int          CHK_XLEN  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    typedef enum logic {
        CHK_REG = 1'b0,
        CHK_MEM = 1'b1
    } chk_kind_e;

    typedef struct packed {
        logic                en;
        chk_kind_e           kind;
        logic [CHK_XLEN-1:0] addr;
        logic [CHK_XLEN-1:0] exp;
    } chk_slot_t;

    // Replace the byte lanes selected by be, keep the others.
    function automatic logic [CHK_XLEN-1:0] merge_lanes(
        input logic [CHK_XLEN-1:0]   old_word,
        input logic [CHK_XLEN-1:0]   new_word,
        input logic [CHK_XLEN/8-1:0] be
    );
        logic [CHK_XLEN-1:0] w;
        w = old_word;
        for (int i = 0; i < CHK_XLEN/8; i++) begin
            if (be[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/riscv_check_slot.sv
// One expected-value slot: holds its configuration and a shadow copy of the
// snooped register or memory word. Memory stores merge per byte lane.
module riscv_check_slot
    import riscv_check_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic                  cfg_en,
    input  logic                  cfg_kind,
    input  logic [CHK_XLEN-1:0]   cfg_addr,
    input  logic [CHK_XLEN-1:0]   cfg_exp,
    input  logic                  clr,
    input  logic                  snoop,
    input  logic                  rf_we,
    input  logic [4:0]            rf_waddr,
    input  logic [CHK_XLEN-1:0]   rf_wdata,
    input  logic                  dm_we,
    input  logic [CHK_XLEN-1:0]   dm_addr,
    input  logic [CHK_XLEN/8-1:0] dm_be,
    input  logic [CHK_XLEN-1:0]   dm_wdata,
    output chk_slot_t             cfg_o,
    output logic [CHK_XLEN-1:0]   shadow_o
);

    chk_slot_t             cfg_q, cfg_d;
    logic [CHK_XLEN-1:0]   shadow_q, shadow_d;
    logic                  rf_hit;
    logic                  dm_hit;
    logic                  unused_lo;

    // Byte offset within the word never affects which word is hit.
    assign unused_lo = ^dm_addr[1:0];

    // x0 writes are architecturally discarded, so they never hit a slot.
    assign rf_hit = snoop && cfg_q.en && (cfg_q.kind == CHK_REG) && rf_we &&
                    (rf_waddr == cfg_q.addr[4:0]) && (rf_waddr != 5'd0);
    assign dm_hit = snoop && cfg_q.en && (cfg_q.kind == CHK_MEM) && dm_we &&
                    (dm_addr[CHK_XLEN-1:2] == cfg_q.addr[CHK_XLEN-1:2]);

    // Configuration load; the top only raises cfg_we outside RUN/CHECK.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            cfg_d.en   = cfg_en;
            cfg_d.kind = chk_kind_e'(cfg_kind);
            cfg_d.addr = cfg_addr;
            cfg_d.exp  = cfg_exp;
        end
    end

    // Shadow update: cleared on run entry, then follows matching writes.
    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            shadow_d = '0;
        end else if (rf_hit) begin
            shadow_d = rf_wdata;
        end else if (dm_hit) begin
            shadow_d = merge_lanes(shadow_q, dm_wdata, dm_be);
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q    <= '0;
            shadow_q <= '0;
        end else begin
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
        end
    end

    assign cfg_o    = cfg_q;
    assign shadow_o = shadow_q;

endmodule

// File: rtl/riscv_commit_checker.sv
// Commit checker top: snoops register-file and data-memory writes into
// NUM_CHECKS slots, detects end of program or timeout, then compares one
// slot per cycle and reports pass/fail, error count and cycle count.
// Optional macro RISCV_CHECK_STUCK_PC_EN: also end the run when pc holds
// the same value for two consecutive RUN cycles (jal x0,0 loop).
module riscv_commit_checker
    import riscv_check_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter int          NUM_CHECKS     = 8,
    parameter int          TIMEOUT_CYCLES = 500,
    parameter int          END_MIN_CYCLES = 5,
    parameter logic [31:0] END_INSTR      = NOP_INSTR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
    input  logic                          cfg_en,
    input  logic                          cfg_kind,
    input  logic [XLEN-1:0]               cfg_addr,
    input  logic [XLEN-1:0]               cfg_exp,
    input  logic [XLEN-1:0]               pc,
    input  logic [31:0]                   instr,
    input  logic                          rf_we,
    input  logic [4:0]                    rf_waddr,
    input  logic [XLEN-1:0]               rf_wdata,
    input  logic                          dm_we,
    input  logic [XLEN-1:0]               dm_addr,
    input  logic [XLEN/8-1:0]             dm_be,
    input  logic [XLEN-1:0]               dm_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0] error_cnt,
    output logic [$clog2(NUM_CHECKS)-1:0] fail_idx,
    output logic [31:0]                   cycle_cnt
);

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int CNT_W = $clog2(NUM_CHECKS+1);

    chk_state_e         state_q, state_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   error_cnt_q, error_cnt_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic [IDX_W-1:0]   check_idx_q, check_idx_d;
    logic               timeout_q, timeout_d;

    logic               cfg_open;
    logic               start_run;
    logic               snoop;
    logic               past_min;
    logic               end_hit;
    logic               timeout_hit;
    logic               mismatch;

    chk_slot_t          slot_cfg    [NUM_CHECKS];
    logic [XLEN-1:0]    slot_shadow [NUM_CHECKS];

    assign cfg_open    = (state_q == IDLE) || (state_q == DONE);
    assign start_run   = start && cfg_open;
    assign snoop       = (state_q == RUN);
    assign past_min    = (cycle_cnt_q > 32'(END_MIN_CYCLES));
    assign timeout_hit = (cycle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    genvar g;
    generate
        for (g = 0; g < NUM_CHECKS; g++) begin : g_slot
            riscv_check_slot u_slot (
                .clk      (clk),
                .reset    (reset),
                .cfg_we   (cfg_we && cfg_open && (cfg_idx == IDX_W'(g))),
                .cfg_en   (cfg_en),
                .cfg_kind (cfg_kind),
                .cfg_addr (cfg_addr),
                .cfg_exp  (cfg_exp),
                .clr      (start_run),
                .snoop    (snoop),
                .rf_we    (rf_we),
                .rf_waddr (rf_waddr),
                .rf_wdata (rf_wdata),
                .dm_we    (dm_we),
                .dm_addr  (dm_addr),
                .dm_be    (dm_be),
                .dm_wdata (dm_wdata),
                .cfg_o    (slot_cfg[g]),
                .shadow_o (slot_shadow[g])
            );
        end
    endgenerate

`ifdef RISCV_CHECK_STUCK_PC_EN
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;

    // Remember last RUN-cycle pc so a self-loop can be recognised.
    always_comb begin
        prev_pc_d = prev_pc_q;
        if (start_run) begin
            prev_pc_d = '0;
        end else if (snoop) begin
            prev_pc_d = pc;
        end
    end

    // Previous-pc register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
        end
    end

    assign end_hit = past_min && ((instr == END_INSTR) || (pc == prev_pc_q));
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign end_hit   = past_min && (instr == END_INSTR);
`endif

    assign mismatch = slot_cfg[check_idx_q].en &&
                      (slot_shadow[check_idx_q] != slot_cfg[check_idx_q].exp);

    // Run/check sequencing, counters and result capture.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        error_cnt_d = error_cnt_q;
        fail_idx_d  = fail_idx_q;
        check_idx_d = check_idx_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    cycle_cnt_d = '0;
                    error_cnt_d = '0;
                    fail_idx_d  = '0;
                    check_idx_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                // End of program wins over a coincident timeout.
                if (end_hit) begin
                    state_d     = CHECK;
                    check_idx_d = '0;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    error_cnt_d = error_cnt_q + CNT_W'(1);
                    if (error_cnt_q == '0) begin
                        fail_idx_d = check_idx_q;
                    end
                end
                if (check_idx_q == IDX_W'(NUM_CHECKS - 1)) begin
                    state_d = DONE;
                end else begin
                    check_idx_d = check_idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            error_cnt_q <= '0;
            fail_idx_q  <= '0;
            check_idx_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            error_cnt_q <= error_cnt_d;
            fail_idx_q  <= fail_idx_d;
            check_idx_q <= check_idx_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = done && (error_cnt_q == '0) && !timeout_q;
    assign timeout   = timeout_q;
    assign error_cnt = error_cnt_q;
    assign fail_idx  = fail_idx_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
